// File: rtl/instr_register_ctrl.sv
// Write/read scheduler in front of the instruction register file: round-robin write
// arbitration, occupancy tracking and FIFO-ordered reads with a valid/ready consumer port.
//
// read FSM states
//   state   | meaning
//   RD_IDLE | no entry presented; waits for a fully written entry
//   RD_ADDR | read_pointer just driven; register file output settles
//   RD_DATA | rd_valid high, read_pointer held until rd_ready
module instr_register_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int OPC_W   = 4,
  parameter int OPD_W   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OPC_W-1:0]  req_opcode,
  input  logic [NUM_REQ*OPD_W-1:0]  req_op_a,
  input  logic [NUM_REQ*OPD_W-1:0]  req_op_b,
  output logic                      load_en,
  output logic [AW-1:0]             write_pointer,
  output logic [OPC_W-1:0]          opcode,
  output logic signed [OPD_W-1:0]   operand_a,
  output logic signed [OPD_W-1:0]   operand_b,
  output logic [AW-1:0]             read_pointer,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [AW:0]               count,
  output logic                      full,
  output logic                      empty
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } rd_state_t;

  rd_state_t         rd_state;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     grant_idx;
  logic [GW-1:0]     cand_idx;
  int                cand;
  logic              accept;
  logic              rd_hs;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       avail;
  logic [OPC_W-1:0]  sel_opcode;
  logic [OPD_W-1:0]  sel_op_a;
  logic [OPD_W-1:0]  sel_op_b;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_hs = rd_valid & rd_ready;
  // Entry whose write is still in flight is not yet readable from the register file.
  assign avail = count - {{AW{1'b0}}, load_en};

  always_comb begin
    req_ready = '0;
    grant_idx = last_grant;
    cand      = 0;
    cand_idx  = '0;
    accept    = 1'b0;
    if (!reset && !full) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand     = (int'(last_grant) + k) % NUM_REQ;
        cand_idx = GW'(cand);
        if (!accept && req_valid[cand_idx]) begin
          accept    = 1'b1;
          grant_idx = cand_idx;
        end
      end
      if (accept) begin
        req_ready[grant_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_opcode = req_opcode[int'(grant_idx)*OPC_W +: OPC_W];
    sel_op_a   = req_op_a[int'(grant_idx)*OPD_W +: OPD_W];
    sel_op_b   = req_op_b[int'(grant_idx)*OPD_W +: OPD_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_en       <= 1'b0;
      write_pointer <= '0;
      wr_ptr        <= '0;
      opcode        <= '0;
      operand_a     <= '0;
      operand_b     <= '0;
      last_grant    <= GW'(NUM_REQ - 1);
    end else begin
      load_en <= accept;
      if (accept) begin
        write_pointer <= wr_ptr;
        wr_ptr        <= wr_ptr + AW'(1);
        opcode        <= sel_opcode;
        operand_a     <= sel_op_a;
        operand_b     <= sel_op_b;
        last_grant    <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (accept && !rd_hs) begin
      count <= count + (AW+1)'(1);
    end else if (!accept && rd_hs) begin
      count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state     <= RD_IDLE;
      rd_ptr       <= '0;
      read_pointer <= '0;
      rd_valid     <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (avail != '0) begin
            read_pointer <= rd_ptr;
            rd_state     <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          rd_valid <= 1'b1;
          rd_state <= RD_DATA;
        end
        RD_DATA: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            rd_ptr   <= rd_ptr + AW'(1);
            if (avail > (AW+1)'(1)) begin
              read_pointer <= rd_ptr + AW'(1);
              rd_state     <= RD_ADDR;
            end else begin
              rd_state <= RD_IDLE;
            end
          end
        end
        default: begin
          rd_valid <= 1'b0;
          rd_state <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Bench for instr_register_ctrl: directed scenarios plus randomized traffic checked
// against a queue/array model of the register file and its FIFO contents.
module tb_instr_register_ctrl;

  localparam int NUM_REQ = 2;
  localparam int DEPTH   = 32;
  localparam int AW      = 5;
  localparam int OPC_W   = 4;
  localparam int OPD_W   = 32;
  localparam logic [OPC_W-1:0] OPC_ADD  = 4'h1;
  localparam logic [OPC_W-1:0] OPC_SUB  = 4'h2;
  localparam logic [OPC_W-1:0] OPC_MULT = 4'h3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*OPC_W-1:0] req_opcode;
  logic [NUM_REQ*OPD_W-1:0] req_op_a;
  logic [NUM_REQ*OPD_W-1:0] req_op_b;
  logic                     load_en;
  logic [AW-1:0]            write_pointer;
  logic [OPC_W-1:0]         opcode;
  logic signed [OPD_W-1:0]  operand_a;
  logic signed [OPD_W-1:0]  operand_b;
  logic [AW-1:0]            read_pointer;
  logic                     rd_valid;
  logic                     rd_ready;
  logic [AW:0]              count;
  logic                     full;
  logic                     empty;

  instr_register_ctrl #(
    .NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .AW(AW), .OPC_W(OPC_W), .OPD_W(OPD_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_op_a(req_op_a), .req_op_b(req_op_b),
    .load_en(load_en), .write_pointer(write_pointer), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b),
    .read_pointer(read_pointer), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                      addr;
    logic [OPC_W-1:0]        opc;
    logic signed [OPD_W-1:0] a;
    logic signed [OPD_W-1:0] b;
  } entry_t;

  entry_t                  q[$];
  logic [OPC_W-1:0]        rf_opc [DEPTH];
  logic signed [OPD_W-1:0] rf_a   [DEPTH];
  logic signed [OPD_W-1:0] rf_b   [DEPTH];
  int m_last, m_wptr, m_count;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = NUM_REQ - 1;
    m_wptr  = 0;
    m_count = 0;
    q.delete();
  endtask

  function automatic int model_grant();
    int i;
    if (m_count == DEPTH) return -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      i = (m_last + k) % NUM_REQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_data(input int i);
    req_opcode[i*OPC_W +: OPC_W] = OPC_W'($urandom);
    req_op_a[i*OPD_W +: OPD_W]   = $urandom;
    req_op_b[i*OPD_W +: OPD_W]   = $urandom;
  endtask

  // One clock: check grant and read data before the edge, then all registered outputs after it.
  task automatic cycle(output int g);
    logic          hs;
    logic          pv;
    logic [AW-1:0] prp;
    entry_t        e;
    entry_t        ne;
    #1;
    g = model_grant();
    for (int i = 0; i < NUM_REQ; i++)
      check("req_ready", 64'(req_ready[i]), 64'(g == i));
    hs = rd_valid && rd_ready;
    if (hs) begin
      if (q.size() == 0) begin
        check("read_with_nothing_queued", 64'(q.size()), 64'(1));
      end else begin
        e = q[0];
        check("rd_read_pointer", 64'(read_pointer), 64'(e.addr));
        check("rd_opcode", 64'(rf_opc[read_pointer]), 64'(e.opc));
        check("rd_op_a", 64'(rf_a[read_pointer]), 64'(e.a));
        check("rd_op_b", 64'(rf_b[read_pointer]), 64'(e.b));
      end
    end
    if (g >= 0) begin
      ne.addr = m_wptr;
      ne.opc  = req_opcode[g*OPC_W +: OPC_W];
      ne.a    = req_op_a[g*OPD_W +: OPD_W];
      ne.b    = req_op_b[g*OPD_W +: OPD_W];
    end
    pv  = rd_valid;
    prp = read_pointer;
    @(posedge clk);
    #1;
    if (hs) begin
      if (q.size() > 0) void'(q.pop_front());
      m_count--;
    end
    if (g >= 0) begin
      q.push_back(ne);
      m_last = g;
      m_wptr = (m_wptr + 1) % DEPTH;
      m_count++;
    end
    check("load_en", 64'(load_en), 64'(g >= 0));
    if (g >= 0) begin
      check("write_pointer", 64'(write_pointer), 64'(ne.addr));
      check("opcode", 64'(opcode), 64'(ne.opc));
      check("operand_a", 64'(operand_a), 64'(ne.a));
      check("operand_b", 64'(operand_b), 64'(ne.b));
    end
    if (load_en) begin
      rf_opc[write_pointer] = opcode;
      rf_a[write_pointer]   = operand_a;
      rf_b[write_pointer]   = operand_b;
    end
    check("count", 64'(count), 64'(m_count));
    check("full", 64'(full), 64'(m_count == DEPTH));
    check("empty", 64'(empty), 64'(m_count == 0));
    if (hs) begin
      check("rd_valid_drop", 64'(rd_valid), 64'(0));
    end else if (pv) begin
      check("rd_valid_hold", 64'(rd_valid), 64'(1));
      check("read_pointer_hold", 64'(read_pointer), 64'(prp));
    end
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check({tag, "_load_en"}, 64'(load_en), 64'(0));
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'(0));
    check({tag, "_count"}, 64'(count), 64'(0));
    check({tag, "_empty"}, 64'(empty), 64'(1));
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = '0;
    rd_ready  = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    int n;
    int g;
    n = 0;
    req_valid = '0;
    rd_ready  = 1'b1;
    while ((m_count > 0 || rd_valid) && n < 200) begin
      cycle(g);
      n++;
    end
    check("drain_count", 64'(count), 64'(0));
    check("drain_rd_valid", 64'(rd_valid), 64'(0));
    rd_ready = 1'b0;
  endtask

  task automatic drive_random(input int g, input int rd_pct);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == g || !req_valid[i]) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        set_data(i);
      end
    end
    rd_ready = ($urandom_range(0, 99) < rd_pct);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    int n;
    int nseen;
    logic [AW-1:0]    rp_seen [3];
    logic [OPC_W-1:0] opc_seen [3];
    logic [OPC_W-1:0] exp_opc [3];
    exp_opc = '{OPC_ADD, OPC_SUB, OPC_MULT};

    reset      = 1'b1;
    req_valid  = '1;
    rd_ready   = 1'b0;
    req_opcode = '0;
    req_op_a   = '0;
    req_op_b   = '0;
    set_data(0);
    set_data(1);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("por_req_ready", 64'(req_ready), 64'(0));
    check("por_load_en", 64'(load_en), 64'(0));
    check("por_rd_valid", 64'(rd_valid), 64'(0));
    check("por_write_pointer", 64'(write_pointer), 64'(0));
    check("por_read_pointer", 64'(read_pointer), 64'(0));
    check("por_opcode", 64'(opcode), 64'(0));
    check("por_operand_a", 64'(operand_a), 64'(0));
    check("por_operand_b", 64'(operand_b), 64'(0));
    check("por_count", 64'(count), 64'(0));
    check("por_empty", 64'(empty), 64'(1));
    check("por_full", 64'(full), 64'(0));
    reset     = 1'b0;
    req_valid = '0;

    // single writer, back-to-back
    req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      cycle(g);
      check("sw_load_en", 64'(load_en), 64'(1));
      check("sw_write_pointer", 64'(write_pointer), 64'(k));
      set_data(0);
    end
    req_valid = '0;
    cycle(g);
    check("sw_load_en_end", 64'(load_en), 64'(0));
    drain();

    // mid-stream reset with seven entries pending and a write in flight
    req_valid = 2'b01;
    for (int k = 0; k < 7; k++) begin
      cycle(g);
      set_data(0);
    end
    check("pre_rst_count", 64'(count), 64'(7));
    check("pre_rst_load_en", 64'(load_en), 64'(1));
    do_reset("midrst");

    // fairness between two always-valid requesters
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("fair_grant", 64'(req_ready), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
      cycle(g);
      if (g >= 0) set_data(g);
    end
    drain();

    // fill to full and wrap
    do_reset("fillrst");
    req_valid = 2'b01;
    for (int k = 0; k < DEPTH; k++) begin
      cycle(g);
      set_data(0);
    end
    #1;
    check("fill_full", 64'(full), 64'(1));
    check("fill_req_ready", 64'(req_ready), 64'(0));
    check("fill_count", 64'(count), 64'(DEPTH));
    cycle(g);
    check("fill_rd_valid", 64'(rd_valid), 64'(1));
    rd_ready = 1'b1;
    cycle(g);
    rd_ready = 1'b0;
    check("wrap_full_clear", 64'(full), 64'(0));
    cycle(g);
    check("wrap_load_en", 64'(load_en), 64'(1));
    check("wrap_write_pointer", 64'(write_pointer), 64'(0));
    drain();

    // read order with a stalled consumer
    do_reset("rdrst");
    req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      set_data(0);
      req_opcode[0 +: OPC_W] = exp_opc[k];
      cycle(g);
    end
    req_valid = '0;
    n = 0;
    while (!rd_valid && n < 20) begin
      cycle(g);
      n++;
    end
    check("ro_rd_valid", 64'(rd_valid), 64'(1));
    check("ro_read_pointer0", 64'(read_pointer), 64'(0));
    repeat (3) cycle(g);
    check("ro_read_pointer_stall", 64'(read_pointer), 64'(0));
    rd_ready = 1'b1;
    nseen = 0;
    n = 0;
    while (nseen < 3 && n < 30) begin
      if (rd_valid) begin
        rp_seen[nseen]  = read_pointer;
        opc_seen[nseen] = rf_opc[read_pointer];
        nseen++;
      end
      cycle(g);
      n++;
    end
    check("ro_reads", 64'(nseen), 64'(3));
    for (int k = 0; k < 3; k++) begin
      check("ro_order_pointer", 64'(rp_seen[k]), 64'(k));
      check("ro_order_opcode", 64'(opc_seen[k]), 64'(exp_opc[k]));
    end
    check("ro_rd_valid_drop", 64'(rd_valid), 64'(0));
    check("ro_empty", 64'(empty), 64'(1));
    rd_ready = 1'b0;

    // collision: accept and read handshake on the same edge at count 5
    req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      set_data(0);
      cycle(g);
    end
    req_valid = '0;
    n = 0;
    while (!(rd_valid && !load_en) && n < 20) begin
      cycle(g);
      n++;
    end
    check("col_count_before", 64'(count), 64'(5));
    check("col_read_pointer_before", 64'(read_pointer), 64'(3));
    set_data(0);
    req_valid = 2'b01;
    rd_ready  = 1'b1;
    cycle(g);
    req_valid = '0;
    rd_ready  = 1'b0;
    check("col_count_after", 64'(count), 64'(5));
    check("col_load_en", 64'(load_en), 64'(1));
    check("col_write_pointer", 64'(write_pointer), 64'(8));
    check("col_read_pointer_after", 64'(read_pointer), 64'(4));
    drain();

    // randomized traffic, alternating read-starved and read-heavy phases
    g = -1;
    for (int k = 0; k < 3000; k++) begin
      drive_random(g, ((k / 200) % 2 == 0) ? 15 : 85);
      cycle(g);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
